key_sw_io_responder: RTL and testbench



---
 rtl/io_map_pkg.sv | 11 +
 rtl/io_debounce.sv | 34 +++
 rtl/key_sw_io_responder.sv | 84 ++++++++
 tb/tb_key_sw_io_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: processor I/O address map and CTRL register bit indices shared by bus responders.
package io_map_pkg;
  localparam logic [31:0] ADDRHEX  = 32'hFFFFF000;
  localparam logic [31:0] ADDRLEDR = 32'hFFFFF020;
  localparam logic [31:0] ADDRKEY  = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW   = 32'hFFFFF090;
  localparam logic [31:0] CTRL_OFF = 32'd4;
  localparam int READY   = 0;
  localparam int OVERRUN = 2;
  localparam int IE      = 4;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer, stability counter and debounced register with a change pulse.
module io_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNTBITS         = 20,
  parameter bit INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             chg
);
  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);
  // sync flops hold the raw pin level, so an idle active-low input resets to all-1
  localparam logic [WIDTH-1:0] SYNC_RST = {WIDTH{INVERT}};
  logic [WIDTH-1:0] s1, s2, val;
  logic [CNTBITS-1:0] cnt;
  assign val = INVERT ? ~s2 : s2;
  assign chg = (cnt == LAST) && (val != dout);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= SYNC_RST;
      s2   <= SYNC_RST;
      cnt  <= '0;
      dout <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      cnt  <= (s1 != s2) ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
      if (chg) dout <= val;
    end
  end
endmodule

// File: rtl/key_sw_io_responder.sv
// key_sw_io_responder: KEY/SW data and control/status registers on the data-memory bus.
// Optional macro KEY_SW_IRQ_EN adds the IE bits and a registered level interrupt.
module key_sw_io_responder
  import io_map_pkg::*;
#(
  parameter int                DBITS           = 32,
  parameter int                KEYBITS         = 4,
  parameter int                SWBITS          = 10,
  parameter logic [DBITS-1:0] ADDRKEY         = io_map_pkg::ADDRKEY,
  parameter logic [DBITS-1:0] ADDRSW          = io_map_pkg::ADDRSW,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                CNTBITS         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  input  logic               re,
  output logic               hit,
  output logic [DBITS-1:0]   rdata,
  output logic               rvalid,
  input  logic [KEYBITS-1:0] key_n,
  input  logic [SWBITS-1:0]  sw,
  output logic               irq
);
  localparam logic [DBITS-1:0] KCTRL_A = ADDRKEY + DBITS'(CTRL_OFF);
  localparam logic [DBITS-1:0] SCTRL_A = ADDRSW + DBITS'(CTRL_OFF);
  logic [KEYBITS-1:0] kval;
  logic [SWBITS-1:0] sval;
  logic [1:0] chg, rdy, ovr, ie, data_rd, ctrl_wr, rdy_clr, ovr_clr;
  logic [DBITS-1:0] kctrl, sctrl, rd_mux;
  logic unused;
  io_debounce #(.WIDTH(KEYBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS), .INVERT(1'b1))
    u_key (.clk(clk), .reset(reset), .din(key_n), .dout(kval), .chg(chg[0]));
  io_debounce #(.WIDTH(SWBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNTBITS(CNTBITS), .INVERT(1'b0))
    u_sw (.clk(clk), .reset(reset), .din(sw), .dout(sval), .chg(chg[1]));
  assign hit = (addr == ADDRKEY) || (addr == KCTRL_A) || (addr == ADDRSW) || (addr == SCTRL_A);
  assign data_rd = {re && addr == ADDRSW, re && addr == ADDRKEY};
  assign ctrl_wr = {we && addr == SCTRL_A, we && addr == KCTRL_A};
  assign rdy_clr = data_rd | (ctrl_wr & {2{~wdata[READY]}});
  assign ovr_clr = ctrl_wr & {2{~wdata[OVERRUN]}};
  assign unused = &{1'b0, wdata};
  always_comb begin
    kctrl = '0;
    sctrl = '0;
    kctrl[READY] = rdy[0];
    kctrl[OVERRUN] = ovr[0];
    kctrl[IE] = ie[0];
    sctrl[READY] = rdy[1];
    sctrl[OVERRUN] = ovr[1];
    sctrl[IE] = ie[1];
    rd_mux = (addr == ADDRKEY) ? DBITS'(kval) : (addr == KCTRL_A) ? kctrl :
             (addr == ADDRSW) ? DBITS'(sval) : sctrl;
  end
  // a change pulse wins over a same-cycle clear, and only raises Overrun if Ready survives the cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy    <= '0;
      ovr    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdy    <= chg | (rdy & ~rdy_clr);
      ovr    <= (chg & rdy & ~rdy_clr) | (ovr & ~ovr_clr);
      rvalid <= re && hit;
      if (re && hit) rdata <= rd_mux;
    end
  end
`ifdef KEY_SW_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie  <= '0;
      irq <= 1'b0;
    end else begin
      ie  <= {ctrl_wr[1] ? wdata[IE] : ie[1], ctrl_wr[0] ? wdata[IE] : ie[0]};
      irq <= |(ie & rdy);
    end
  end
`else
  assign ie  = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_key_sw_io_responder.sv
// tb_key_sw_io_responder: directed bus reads with a queued scoreboard checked by a separate monitor.
module tb_key_sw_io_responder;
  localparam logic [31:0] KD = 32'hFFFFF080, KC = 32'hFFFFF084, SD = 32'hFFFFF090, SC = 32'hFFFFF094;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, re = 1'b0, hit, rvalid, irq;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] key_n = 4'hF;
  logic [9:0] sw = '0;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  string name_q[$];

  key_sw_io_responder #(.DEBOUNCE_CYCLES(4), .CNTBITS(3)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re), .hit(hit),
    .rdata(rdata), .rvalid(rvalid), .key_n(key_n), .sw(sw), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    re = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick(1);
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && rvalid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid got=%h want=none", rdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (rdata !== e) begin
          bad++;
          $display("FAIL %s got=%h want=%h", n, rdata, e);
        end
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    // reset state, address decode and an unowned read
    check("irq_reset", {31'b0, irq}, 32'h0);
    addr = KC; #1 check("hit_kctrl", {31'b0, hit}, 32'h1);
    addr = KD + 32'd8; #1 check("hit_miss", {31'b0, hit}, 32'h0);
    tick(1);
    rd("t1_kdata", KD, 32'h0);
    rd("t1_kctrl", KC, 32'h0);
    rd("t1_sdata", SD, 32'h0);
    rd("t1_sctrl", SC, 32'h0);
    addr = 32'h0;
    re = 1'b1;
    tick(1);
    re = 1'b0;
    // single key press
    key_n = 4'hE;
    tick(6);
    rd("t2_kctrl_set", KC, 32'h1);
    rd("t2_kdata", KD, 32'h1);
    rd("t2_kctrl_clr", KC, 32'h0);
    // toggling switches settle to one change
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 1) ? 10'h2AA : 10'h155;
      tick(2);
    end
    tick(8);
    rd("t3_sctrl", SC, 32'h1);
    rd("t3_sdata", SD, 32'h2AA);
    // overrun and CTRL write clearing
    key_n = 4'hF;
    tick(8);
    key_n = 4'hC;
    tick(8);
    rd("t4_kctrl_ovr", KC, 32'h5);
    wr(KC, 32'h0);
    rd("t4_kctrl_wr0", KC, 32'h0);
    wr(KC, 32'h5);
    rd("t4_kctrl_wr5", KC, 32'h0);
    rd("t4_kdata", KD, 32'h3);
    // change pulse coincident with a data read
    key_n = 4'hF;
    tick(5);
    rd("t5_kdata_old", KD, 32'h3);
    rd("t5_kctrl", KC, 32'h1);
    key_n = 4'hE;
    tick(5);
    rd("t5_kdata_old2", KD, 32'h0);
    rd("t5_kctrl_noovr", KC, 32'h1);
    // interrupt
    wr(SC, 32'h10);
    check("t6_irq_idle", {31'b0, irq}, 32'h0);
    sw = 10'h001;
    tick(6);
    check("t6_irq_same", {31'b0, irq}, 32'h0);
    tick(1);
`ifdef KEY_SW_IRQ_EN
    check("t6_irq_set", {31'b0, irq}, 32'h1);
    rd("t6_sdata", SD, 32'h001);
    tick(1);
    check("t6_irq_clr", {31'b0, irq}, 32'h0);
    rd("t6_sctrl", SC, 32'h10);
`else
    check("t6_irq_off", {31'b0, irq}, 32'h0);
    rd("t6_sctrl", SC, 32'h1);
    rd("t6_sdata", SD, 32'h001);
    check("t6_irq_off2", {31'b0, irq}, 32'h0);
`endif
    // asynchronous reset drops an in-flight read
    tick(2);
    addr = KD;
    re = 1'b1;
    tick(1);
    re = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset = 1'b0;
    rd("rst_kdata", KD, 32'h0);
    rd("rst_kctrl", KC, 32'h0);
    tick(3);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
